// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported unified I/D memory between instruction fetch
//   and the data (load/store) stage. One transaction is in flight at a time:
//   IDLE -> ISSUE -> WAIT -> IDLE, or IDLE -> ERR -> IDLE for an illegal
//   data access. Data wins simultaneous arbitration.
//
//   Optional feature, macro STARVE_GUARD_EN: once MAX_D_STREAK data grants
//   have been made back-to-back while fetch was waiting, the next
//   arbitration that sees if_req goes to fetch.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   if_req/if_addr -> if_gnt          fetch request / accept pulse
//   if_rvalid/if_rdata                instruction return (rdata holds)
//   d_req/d_we/d_size/d_unsigned/
//   d_addr/d_wdata -> d_gnt           data request / accept pulse
//   d_rvalid/d_rdata/d_err            data response (rdata holds)
//   mem_req/we/addr/be/wdata          memory command (mem_req 1-cycle)
//   mem_rdata/mem_rvalid              memory response, L>=1 after mem_req
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_unsigned,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rvalid
);

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERR} state_t;

    if (MAX_D_STREAK < 1) begin : g_bad_param
        $error("MAX_D_STREAK must be at least 1");
    end

    state_t            state_q;
    logic              owner_d_q;   // 1 = data stage owns the transaction
    logic              we_q;
    logic              uns_q;
    logic [1:0]        size_q;
    logic [1:0]        lo_q;        // byte offset, selects the load lane
    logic              mem_req_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [3:0]        mem_be_q;
    logic [31:0]       mem_wdata_q;
    logic              if_rvalid_q, d_rvalid_q, d_err_q;
    logic [31:0]       if_rdata_q, d_rdata_q;

    logic       idle, pick_d, d_illegal;
    logic [3:0] be_d;
    logic [31:0] wdata_d;

    assign idle = (state_q == IDLE);

`ifdef STARVE_GUARD_EN
    localparam int SW = ($clog2(MAX_D_STREAK + 1) > 3) ? $clog2(MAX_D_STREAK + 1) : 3;
    logic [SW-1:0] streak_q;
    logic          fetch_due;

    assign fetch_due = if_req && (streak_q == SW'(MAX_D_STREAK));
    assign pick_d    = d_req && !fetch_due;

    // Counts data grants that made a waiting fetch wait again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      streak_q <= '0;
        else if (d_gnt)  streak_q <= if_req ? streak_q + SW'(1) : '0;
        else if (if_gnt) streak_q <= '0;
    end
`else
    assign pick_d = d_req;
`endif

    assign d_gnt  = idle && pick_d;
    assign if_gnt = idle && if_req && !pick_d;

    assign d_illegal = (d_size == 2'b11) ||
                       (d_size == 2'b01 && d_addr[0]) ||
                       (d_size == 2'b10 && d_addr[1:0] != 2'b00);

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = d_wdata;
        case (d_size)
            2'b00: begin
                be_d    = 4'b0001 << d_addr[1:0];
                wdata_d = {4{d_wdata[7:0]}};
            end
            2'b01: begin
                be_d    = d_addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{d_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] lo,
                                              input logic [1:0] sz, input logic u);
        logic [31:0] sh;
        sh = w >> {lo, 3'b000};
        case (sz)
            2'b00:   return u ? {24'b0, sh[7:0]}   : {{24{sh[7]}}, sh[7:0]};
            2'b01:   return u ? {16'b0, sh[15:0]}  : {{16{sh[15]}}, sh[15:0]};
            default: return w;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_d_q   <= 1'b0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= 2'b00;
            lo_q        <= 2'b00;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= NOP;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
            d_err_q     <= 1'b0;
        end else begin
            mem_req_q   <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (d_gnt) begin
                        owner_d_q <= 1'b1;
                        we_q      <= d_we;
                        uns_q     <= d_unsigned;
                        size_q    <= d_size;
                        lo_q      <= d_addr[1:0];
                        if (d_illegal) begin
                            state_q <= ERR;
                        end else begin
                            state_q     <= ISSUE;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= d_we;
                            mem_addr_q  <= d_addr & WORD_MASK;
                            mem_be_q    <= be_d;
                            mem_wdata_q <= wdata_d;
                        end
                    end else if (if_gnt) begin
                        owner_d_q  <= 1'b0;
                        state_q    <= ISSUE;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= if_addr & WORD_MASK;
                        mem_be_q   <= 4'b1111;
                    end
                end
                ISSUE: state_q <= WAIT;
                WAIT: begin
                    if (mem_rvalid) begin
                        state_q <= IDLE;
                        if (owner_d_q) begin
                            d_rvalid_q <= 1'b1;
                            d_err_q    <= 1'b0;
                            d_rdata_q  <= we_q ? 32'h0 : load_ext(mem_rdata, lo_q, size_q, uns_q);
                        end else begin
                            if_rvalid_q <= 1'b1;
                            if_rdata_q  <= mem_rdata;
                        end
                    end
                end
                ERR: begin
                    state_q    <= IDLE;
                    d_rvalid_q <= 1'b1;
                    d_err_q    <= 1'b1;
                    d_rdata_q  <= 32'h0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;

endmodule
